shift_register_group_param: RTL

Parametrised multi-channel delay line: the successor to the fixed 18-bit, 3-deep, 32-channel shift-register group used to align operands in the LSTM datapath. Channel count, word width and maximum depth are generics; the active delay is selectable at run time. Each stage carries a valid bit, and a synchronous flush is provided. It sits between the matrix-vector stage and the element-wise stage. Downstream logic can qualify data with `out_valid` and `primed` instead of counting cycles externally.

---
 rtl/lstm_pkg.sv | 20 ++
 rtl/shift_register_lane.sv | 52 +++++
 rtl/shift_register_group_param.sv | 85 ++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// Shared LSTM datapath defaults and helpers for delay-aligned blocks.
package lstm_pkg;

  localparam int LSTM_WIDTH     = 18;
  localparam int LSTM_MAX_DEPTH = 8;

  // Map a run-time depth request onto the implemented range 1..max_depth.
  function automatic int clamp_depth(input int sel, input int max_depth);
    int eff;
    if (sel < 1) begin
      eff = 1;
    end else if (sel > max_depth) begin
      eff = max_depth;
    end else begin
      eff = sel;
    end
    return eff;
  endfunction

endpackage

// File: rtl/shift_register_lane.sv
// One lane of the delay line: WIDTH x MAX_DEPTH stage chain with an output tap mux.
module shift_register_lane
  import lstm_pkg::*;
#(
  parameter int WIDTH     = LSTM_WIDTH,
  parameter int MAX_DEPTH = LSTM_MAX_DEPTH,
  parameter int TAP_W     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             enable_i,
  input  logic [TAP_W-1:0] tap_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [MAX_DEPTH];
  logic [WIDTH-1:0] stage_d [MAX_DEPTH];

  // Next-state of the chain: flush clears, enable shifts, otherwise hold.
  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        stage_d[k] = '0;
      end
    end else if (enable_i) begin
      stage_d[0] = data_i;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end else begin
      stage_d = stage_q;
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // Tap index is always below MAX_DEPTH because the depth is clamped upstream.
  assign data_o = stage_q[tap_i];

endmodule

// File: rtl/shift_register_group_param.sv
// Parametrised multi-channel delay line with run-time depth, shared valid chain and prime flag.
module shift_register_group_param
  import lstm_pkg::*;
#(
  parameter int CHANNELS  = 32,
  parameter int WIDTH     = LSTM_WIDTH,
  parameter int MAX_DEPTH = LSTM_MAX_DEPTH,
  parameter int DSEL_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [DSEL_W-1:0]         depth_sel,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic                      primed
);

  localparam int TAP_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [DSEL_W-1:0]    eff_depth_s;
  logic [TAP_W-1:0]     tap_s;
  logic [MAX_DEPTH-1:0] vld_q, vld_d;
  logic [DSEL_W-1:0]    shift_cnt_q, shift_cnt_d;

  assign eff_depth_s = DSEL_W'(clamp_depth(int'(depth_sel), MAX_DEPTH));
  assign tap_s       = TAP_W'(eff_depth_s - DSEL_W'(1));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    shift_register_lane #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH),
      .TAP_W     (TAP_W)
    ) u_lane (
      .clk_i    (clk),
      .reset_i  (reset),
      .flush_i  (flush),
      .enable_i (enable),
      .tap_i    (tap_s),
      .data_i   (in_data[c*WIDTH +: WIDTH]),
      .data_o   (out_data[c*WIDTH +: WIDTH])
    );
  end

  // Shared valid chain and saturating shift counter, same priority as the lanes.
  always_comb begin
    vld_d       = vld_q;
    shift_cnt_d = shift_cnt_q;
    if (flush) begin
      vld_d       = '0;
      shift_cnt_d = '0;
    end else if (enable) begin
      vld_d[0] = in_valid;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
      end
      if (shift_cnt_q < DSEL_W'(MAX_DEPTH)) begin
        shift_cnt_d = shift_cnt_q + DSEL_W'(1);
      end else begin
        shift_cnt_d = shift_cnt_q;
      end
    end else begin
      vld_d       = vld_q;
      shift_cnt_d = shift_cnt_q;
    end
  end

  // Valid and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q       <= '0;
      shift_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  assign out_valid = vld_q[tap_s];
  assign primed    = (shift_cnt_q >= eff_depth_s);

endmodule
